// File: rtl/intf_stage.sv
// rtl/intf_stage.sv - cascaded 2-phase click-stage bundled-data pipeline
//
// Purpose:
//   A chain of STAGES synchronous 2-phase "click" stages. Each stage owns a
//   request flop and a data register. A stage captures a new token when its
//   input channel carries a pending token and its output channel is empty.
//   All handshakes are transition-signalled: every toggle of a request is one
//   new token, and every toggle of an acknowledge releases one token.
//
// Ports:
//   clk     in   1      rising-edge clock, all state updates on this edge
//   rst     in   1      asynchronous active-high reset, clears every stage
//   a_req   in   1      input channel request (toggle = new token)
//   a_data  in   WIDTH  input channel data, valid while a_req != a_ack
//   a_ack   out  1      input channel acknowledge (request flop of stage 0)
//   b_req   out  1      output channel request (request flop of last stage)
//   b_data  out  WIDTH  output channel data, valid while b_req != b_ack
//   b_ack   in   1      output channel acknowledge from the consumer
//
// Inputs are assumed synchronous to clk; there are no synchronizers.

module intf_stage #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ack,
  output logic             b_req,
  output logic [WIDTH-1:0] b_data,
  input  logic             b_ack
);

  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $error("intf_stage: STAGES must be in 1..16");
  end

  // Per-stage request flops and data registers.
  logic [STAGES-1:0] r;
  logic [WIDTH-1:0]  d [STAGES];

  // Request chain with both channel ends attached:
  //   chain[0]          = a_req   (request into stage 0)
  //   chain[k+1]        = r[k]
  //   chain[STAGES+1]   = b_ack   (acknowledge into the last stage)
  // Stage k then sees its input request at chain[k], its own flop at
  // chain[k+1] and its downstream flop at chain[k+2].
  logic [STAGES+1:0] chain;
  assign chain = {b_ack, r, a_req};

  // Data presented to each stage's input.
  logic [WIDTH-1:0] d_in [STAGES];

  // Fire terms use only pre-edge values. Neighbouring stages can never fire
  // together: stage k firing needs r[k] == r[k+1], stage k+1 firing needs
  // r[k] != r[k+1]. This is what lets d[k-1] be sampled safely by stage k,
  // since stage k-1 cannot overwrite it on the same edge.
  logic [STAGES-1:0] fire;

  always_comb begin
    fire = '0;
    for (int k = 0; k < STAGES; k++) begin
      fire[k] = (chain[k] != chain[k+1]) && (chain[k+1] == chain[k+2]);
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      d_in[k] = '0;
    end
    d_in[0] = a_data;
    for (int k = 1; k < STAGES; k++) begin
      d_in[k] = d[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (fire[k]) begin
          r[k] <= ~r[k];
          d[k] <= d_in[k];
        end
      end
    end
  end

  // Outputs come straight from flops, so no input reaches an output
  // combinationally.
  assign a_ack  = r[0];
  assign b_req  = r[STAGES-1];
  assign b_data = d[STAGES-1];

endmodule

// File: tb/tb_intf_stage.sv
// tb/tb_intf_stage.sv - directed, table-driven bench for intf_stage

module tb_intf_stage;

  localparam int WIDTH  = 8;
  localparam int STAGES = 3;

  logic             clk    = 1'b0;
  logic             rst    = 1'b0;
  logic             a_req  = 1'b0;
  logic [WIDTH-1:0] a_data = '0;
  logic             b_ack  = 1'b0;
  logic             a_ack;
  logic             b_req;
  logic [WIDTH-1:0] b_data;

  intf_stage #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_req  (a_req),
    .a_data (a_data),
    .a_ack  (a_ack),
    .b_req  (b_req),
    .b_data (b_data),
    .b_ack  (b_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, " a_ack"}, {31'd0, a_ack}, 32'd0);
    check({name, " b_req"}, {31'd0, b_req}, 32'd0);
    check({name, " b_data"}, {24'd0, b_data}, 32'd0);
  endtask

  // Advance one clock edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             a_req;
    logic [WIDTH-1:0] a_data;
    logic             b_ack;
    logic             e_ack;
    logic             e_breq;
    logic [WIDTH-1:0] e_bdata;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] exp_d;
    logic             hold_req;
    int sent, rcvd, cyc, lat;

    // Single token, then fill/backpressure with 0x01..0x04, then drain.
    // Fields: a_req, a_data, b_ack -> a_ack, b_req, b_data after the edge.
    vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01};
    vecs[3]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01};
    vecs[4]  = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01};
    vecs[5]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'h01};
    vecs[6]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h01};
    vecs[7]  = '{1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 8'h01};
    vecs[8]  = '{1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[9]  = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[10] = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[11] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h02};
    vecs[12] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h02};
    vecs[13] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h02};
    vecs[14] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'h03};
    vecs[15] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 8'h03};
    vecs[16] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h04};
    vecs[17] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h04};

    // Reset asserted between edges: outputs must clear with no edge.
    #2 rst = 1'b1;
    #1 check_zero("reset_async");
    a_req  = 1'b1;
    b_ack  = 1'b1;
    a_data = 8'hFF;
    tick();
    tick();
    check_zero("reset_hold");
    a_req  = 1'b0;
    b_ack  = 1'b0;
    a_data = 8'h00;
    rst    = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      a_req  = vecs[i].a_req;
      a_data = vecs[i].a_data;
      b_ack  = vecs[i].b_ack;
      tick();
      check($sformatf("vec%0d a_ack", i), {31'd0, a_ack}, {31'd0, vecs[i].e_ack});
      check($sformatf("vec%0d b_req", i), {31'd0, b_req}, {31'd0, vecs[i].e_breq});
      check($sformatf("vec%0d b_data", i), {24'd0, b_data}, {24'd0, vecs[i].e_bdata});
    end

    // Streaming 256 tokens with a sender that toggles as soon as it is
    // acknowledged and a receiver that acknowledges one cycle after b_req.
    nxt   = 8'h01;
    exp_d = 8'h01;
    sent  = 0;
    rcvd  = 0;
    cyc   = 0;
    while (rcvd < 256 && cyc < 1000) begin
      if (b_req != b_ack) begin
        check($sformatf("stream tok%0d", rcvd), {24'd0, b_data}, {24'd0, exp_d});
        exp_d = exp_d + 8'h01;
        rcvd++;
        b_ack = b_req;
      end
      if (a_ack == a_req && sent < 256) begin
        a_data = nxt;
        nxt    = nxt + 8'h01;
        a_req  = ~a_req;
        sent++;
      end
      tick();
      cyc++;
    end
    check("stream count", rcvd, 32'd256);
    check("stream rate", {31'd0, cyc <= 2 * 256 + STAGES + 4}, 32'd1);

    // Data stability: park a token at the output, wiggle a_data while idle.
    a_data = 8'hA5;
    a_req  = ~a_req;
    tick();
    tick();
    tick();
    check("park b_req", {31'd0, b_req}, {31'd0, !b_ack});
    check("park b_data", {24'd0, b_data}, 32'h0000_00A5);
    hold_req = b_req;
    for (int i = 0; i < 10; i++) begin
      a_data = WIDTH'($urandom);
      tick();
      check($sformatf("stable%0d b_data", i), {24'd0, b_data}, 32'h0000_00A5);
      check($sformatf("stable%0d b_req", i), {31'd0, b_req}, {31'd0, hold_req});
      check($sformatf("stable%0d a_ack", i), {31'd0, a_ack}, {31'd0, a_req});
    end
    b_ack = b_req;
    tick();
    tick();
    tick();
    check("stable drained b_data", {24'd0, b_data}, 32'h0000_00A5);
    check("stable drained b_req", {31'd0, b_req}, {31'd0, b_ack});

    // Reset with two tokens in flight.
    a_data = 8'h11;
    a_req  = ~a_req;
    tick();
    a_data = 8'h22;
    a_req  = ~a_req;
    tick();
    #2 rst = 1'b1;
    #1 check_zero("midreset_async");
    a_req  = 1'b0;
    b_ack  = 1'b0;
    a_data = 8'h00;
    tick();
    tick();
    check_zero("midreset_hold");
    rst = 1'b0;

    // Fresh token after reset: a_ack after 1 edge, b_req after STAGES edges.
    a_data = 8'h55;
    a_req  = 1'b1;
    lat    = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 1) check("post_reset a_ack", {31'd0, a_ack}, 32'd1);
      if (b_req && lat == 0) lat = e;
    end
    check("post_reset latency", lat, STAGES);
    check("post_reset b_data", {24'd0, b_data}, 32'h0000_0055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intf_stage.md
INTF_STAGE -- requirements
Module: intf_stage

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the bundled data on both channels.
REQ-002 Parameter STAGES, default 3: number of cascaded 2-phase click stages, legal range 1..16.
REQ-003 The block SHALL have one clock, and the reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock; all state updates occur on this edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 a_req  input  1  input channel 2-phase request; every transition is one new token.
REQ-007 a_data  input  WIDTH  input channel data, valid whenever a_req != a_ack.
REQ-008 a_ack  output  1  input channel 2-phase acknowledge.
REQ-009 b_req  output  1  output channel 2-phase request.
REQ-010 b_data  output  WIDTH  output channel data, valid whenever b_req != b_ack.
REQ-011 b_ack  input  1  output channel 2-phase acknowledge from the consumer.
REQ-012 a_req, a_data and b_ack SHALL be treated as synchronous to clk, with no internal synchronizers.

Function
REQ-013 Internal state per stage k (k = 0..STAGES-1) SHALL be a request flop r[k] and a data register d[k] of WIDTH bits.
REQ-014 Define r[-1] = a_req, d[-1] = a_data and r[STAGES] = b_ack.
REQ-015 Stage k fires on a clock edge when r[k-1] != r[k] (a token is pending at its input) and r[k] == r[k+1] (its output is empty); all fire terms SHALL use pre-edge values.
REQ-016 On fire, r[k] SHALL toggle and d[k] SHALL load d[k-1]; otherwise r[k] and d[k] SHALL hold.
REQ-017 Outputs: a_ack = r[0]; b_req = r[STAGES-1]; b_data = d[STAGES-1]; no combinational path from inputs to outputs.
REQ-018 Adjacent stages are mutually exclusive per edge by construction, because their fire conditions contradict each other.
REQ-019 Sustained throughput SHALL be one token every 2 cycles.
REQ-020 Empty-pipeline latency: a_ack toggles 1 edge after an a_req transition, and b_req toggles STAGES edges after that a_req transition.
REQ-021 Stage k holds a token when r[k] != r[k+1].
REQ-022 Capacity SHALL be STAGES tokens.
REQ-023 When full, further a_req transitions SHALL NOT be acknowledged until b_ack toggles.
REQ-024 Tokens SHALL exit in arrival order with no loss or duplication.
REQ-025 a_data changes while a_req == a_ack SHALL have no effect on state.
REQ-026 A toggling b_ack while b_req == b_ack is a protocol violation; no recovery is required.

Reset
REQ-027 While rst=1, all r[k] SHALL be 0 and all d[k] SHALL be 0, so a_ack=0, b_req=0 and b_data=0.
REQ-028 Reset SHALL take effect immediately, without waiting for a clock edge.
REQ-029 Reset mid-operation SHALL discard all in-flight tokens.
REQ-030 The environment SHALL drive a_req=0 and b_ack=0 before rst deasserts.
REQ-031 The first edge after deassertion evaluates normally.

Verification
REQ-032 Reset: assert rst with random internal state -> a_ack=0, b_req=0 and b_data=0 with no clock edge; hold these values while rst=1.
REQ-033 Single token (STAGES=3): a_data=0x01, a_req 0->1, b_ack=0 -> a_ack=1 after edge 1; b_req=1 and b_data=0x01 after edge 3.
REQ-034 Fill/backpressure: b_ack held, tokens 0x01, 0x02 and 0x03 sent -> all acked; b_req=1, b_data=0x01. Fourth token 0x04 -> a_ack stays != a_req. Toggle b_ack -> b_data becomes 0x02, then 0x04 is acked.
REQ-035 Streaming: sender increments data each phase (0x01, 0x02, ...) and toggles a_req once a_ack == a_req; receiver copies b_req to b_ack next cycle -> 256 tokens arrive in order, no gaps or duplicates, data wraps 0xFF->0x00 correctly.
REQ-036 Reset mid-stream: rst pulsed with 2 tokens in flight -> outputs 0 immediately; after re-reset of environment, token 0x55 passes with latency STAGES.
REQ-037 Data stability: a_data toggled randomly while a_req == a_ack -> b_data unchanged.
